rptr_empty_ctrl: RTL

Read-domain pointer, empty-flag and fill-level controller for the async FIFO, parametrised in depth, data width and read mode. It produces the Gray read pointer for the write-domain synchronizer, drives the FIFO memory read port, and computes a registered fill level with a programmable almost-empty flag. In first-word-fall-through (FWFT) mode it adds a 2-entry output buffer that hides the memory's 1-cycle read latency while sustaining one word per cycle.

---
 rtl/async_fifo_pkg.sv | 23 ++
 rtl/rptr_empty_ctrl_fwft_obuf.sv | 53 +++++
 rtl/rptr_empty_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Gray/binary pointer conversions shared by the read- and write-side pointer blocks.
// Operands of any width up to PTR_W_MAX are zero-extended in; cast the result back to pointer width.
package async_fifo_pkg;

  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_ctrl_fwft_obuf.sv
// Two-entry head/skid output buffer hiding the 1-cycle memory read latency in FWFT mode.
// Tracks buffered words (cnt) and a fetch issued last cycle (inflight); data lands the cycle after the fetch.
module fwft_obuf #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             i_pop,
  input  logic             i_fetch,
  input  logic [DSIZE-1:0] i_rdata,
  output logic [1:0]       o_cnt,
  output logic [1:0]       o_cnt_next,
  output logic             o_inflight,
  output logic [DSIZE-1:0] o_head
);

  logic [1:0]       r_cnt;
  logic             r_inflight;
  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_skid;
  logic [1:0]       w_cnt_after_pop;

  assign w_cnt_after_pop = r_cnt - {1'b0, i_pop};
  assign o_cnt_next      = w_cnt_after_pop + {1'b0, r_inflight};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_inflight <= i_fetch;
      r_cnt      <= o_cnt_next;
      if (i_pop) begin
        r_head <= r_skid;
      end
      // An arriving word goes straight to head only if nothing is left in front of it.
      if (r_inflight) begin
        if (w_cnt_after_pop == 2'd0) begin
          r_head <= i_rdata;
        end else begin
          r_skid <= i_rdata;
        end
      end
    end
  end

  assign o_cnt      = r_cnt;
  assign o_inflight = r_inflight;
  assign o_head     = r_head;

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty flag and registered fill level for the async FIFO.
// FWFT=1 adds a head/skid buffer so data is presented before the pop at full rate.
module rptr_empty_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int DSIZE    = 8,
  parameter int FWFT     = 0
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   aempty_th,
  input  logic [DSIZE-1:0]    rmem_rdata,
  output logic                rmem_ren,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [DSIZE-1:0]    rdata,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rlevel;
  logic          r_empty_int;
  logic          r_arempty;

  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_rbinnext;
  logic [PW-1:0] w_rgraynext;
  logic [PW-1:0] w_level_next;
  logic          w_fetch_ok;
  logic          w_fetch;

  assign w_wbin      = PW'(gray2bin(ptr_word_t'(rq2_wptr)));
  assign w_fetch     = ~r_empty_int & w_fetch_ok;
  assign w_rbinnext  = r_rbin + PW'(w_fetch);
  assign w_rgraynext = PW'(bin2gray(ptr_word_t'(w_rbinnext)));

  // Level is wbin minus what the consumer has taken; modular subtraction absorbs pointer wrap.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin      <= '0;
      r_rptr      <= '0;
      r_empty_int <= 1'b1;
      r_rlevel    <= '0;
      r_arempty   <= 1'b1;
    end else begin
      r_rbin      <= w_rbinnext;
      r_rptr      <= w_rgraynext;
      r_empty_int <= (w_rgraynext == rq2_wptr);
      r_rlevel    <= w_level_next;
      r_arempty   <= (w_level_next <= aempty_th);
    end
  end

  assign rmem_ren = w_fetch;
  assign raddr    = r_rbin[ADDRSIZE-1:0];
  assign rptr     = r_rptr;
  assign rlevel   = r_rlevel;
  assign arempty  = r_arempty;

  generate
    if (FWFT != 0) begin : g_fwft
      logic [1:0] w_cnt;
      logic [1:0] w_cnt_next;
      logic       w_inflight;
      logic       w_pop;
      logic [2:0] w_occ;

      assign w_pop      = rinc & (w_cnt != 2'd0);
      assign w_occ      = {1'b0, w_cnt} + {2'b00, w_inflight} - {2'b00, w_pop};
      assign w_fetch_ok = (w_occ < 3'd2);

      fwft_obuf #(.DSIZE(DSIZE)) u_obuf (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .i_pop      (w_pop),
        .i_fetch    (w_fetch),
        .i_rdata    (rmem_rdata),
        .o_cnt      (w_cnt),
        .o_cnt_next (w_cnt_next),
        .o_inflight (w_inflight),
        .o_head     (rdata)
      );

      assign rempty       = (w_cnt == 2'd0);
      assign w_level_next = (w_wbin - w_rbinnext) + PW'(w_cnt_next) + PW'(w_fetch);
    end else begin : g_std
      assign w_fetch_ok   = rinc;
      assign rempty       = r_empty_int;
      assign rdata        = rmem_rdata;
      assign w_level_next = w_wbin - w_rbinnext;
    end
  endgenerate

endmodule
